// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: arbiter FSM state encoding and default ALU opcodes.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_EXEC  = 2'b10,
    ST_DONE  = 2'b11
  } arb_state_t;

  localparam logic [5:0] ALU_OP_ADD = 6'b100000;
  localparam logic [5:0] ALU_OP_SUB = 6'b100010;
  localparam logic [5:0] ALU_OP_AND = 6'b100100;

  // Wide enough for the largest legal ALU latency (15).
  localparam int unsigned LAT_CNT_W = 4;

endpackage

// File: rtl/alu_arbiter_rr_arbiter_2.sv
// Two-way round-robin select: a lone request wins; on contention the pointer decides.
module rr_arbiter_2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_ptr,
  output logic o_valid,
  output logic o_winner
);

  always_comb begin
    o_valid  = i_req0 | i_req1;
    o_winner = 1'b0;
    if (i_req0 && i_req1) begin
      o_winner = i_ptr;
    end else if (i_req1) begin
      o_winner = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: round-robin grant, registered
// operands, fixed-latency result capture and per-requester done pulse.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OPCODE_SZ  = 6,
  parameter int unsigned ALU_LAT    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req0,
  input  logic                  i_req1,
  input  logic [DATA_WIDTH-1:0] i_op_a0,
  input  logic [DATA_WIDTH-1:0] i_op_b0,
  input  logic [DATA_WIDTH-1:0] i_op_a1,
  input  logic [DATA_WIDTH-1:0] i_op_b1,
  input  logic [OPCODE_SZ-1:0]  i_op_code0,
  input  logic [OPCODE_SZ-1:0]  i_op_code1,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  output logic [DATA_WIDTH-1:0] o_op_a,
  output logic [DATA_WIDTH-1:0] o_op_b,
  output logic [OPCODE_SZ-1:0]  o_op_code,
  output logic                  o_gnt0,
  output logic                  o_gnt1,
  output logic                  o_done0,
  output logic                  o_done1,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_busy
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(ALU_LAT);
  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(1);

  arb_state_t           state, state_nxt;
  logic                 ptr;
  logic                 winner;
  logic                 sel_valid;
  logic                 sel_winner;
  logic [LAT_CNT_W-1:0] cnt;

  rr_arbiter_2 u_rr (
    .i_req0   (i_req0),
    .i_req1   (i_req1),
    .i_ptr    (ptr),
    .o_valid  (sel_valid),
    .o_winner (sel_winner)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:  state_nxt = sel_valid ? ST_GRANT : ST_IDLE;
      ST_GRANT: state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = (cnt == LAT_LAST) ? ST_DONE : ST_EXEC;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign o_busy = (state != ST_IDLE);

  // Grant/done pulses default low every cycle; only their owning state raises them.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ptr       <= 1'b0;
      winner    <= 1'b0;
      cnt       <= '0;
      o_op_a    <= '0;
      o_op_b    <= '0;
      o_op_code <= '0;
      o_result  <= '0;
      o_gnt0    <= 1'b0;
      o_gnt1    <= 1'b0;
      o_done0   <= 1'b0;
      o_done1   <= 1'b0;
    end else begin
      o_gnt0  <= 1'b0;
      o_gnt1  <= 1'b0;
      o_done0 <= 1'b0;
      o_done1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            winner <= sel_winner;
          end
        end
        ST_GRANT: begin
          o_op_a    <= winner ? i_op_a1    : i_op_a0;
          o_op_b    <= winner ? i_op_b1    : i_op_b0;
          o_op_code <= winner ? i_op_code1 : i_op_code0;
          o_gnt0    <= ~winner;
          o_gnt1    <= winner;
          cnt       <= LAT_LOAD;
        end
        ST_EXEC: begin
          cnt <= cnt - LAT_LAST;
          if (cnt == LAT_LAST) begin
            o_result <= i_alu_result;
            ptr      <= ~winner;
          end
        end
        ST_DONE: begin
          o_done0 <= ~winner;
          o_done1 <= winner;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand/result width in bits.
REQ-002 Parameter OPCODE_SZ, default 6, ALU opcode width.
REQ-003 Parameter ALU_LAT, default 1, ALU cycles from operand-stable to result-valid; legal 1..15.
REQ-004 i_clk  in  1  single clock, all state on rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_req0 / i_req1  in  1  level request from requester 0 (UART interface) / 1 (switch panel).
REQ-007 i_op_a0, i_op_b0 / i_op_a1, i_op_b1  in  DATA_WIDTH  operands per requester.
REQ-008 i_op_code0 / i_op_code1  in  OPCODE_SZ  opcode per requester.
REQ-009 i_alu_result  in  DATA_WIDTH  shared ALU result.
REQ-010 o_op_a, o_op_b  out  DATA_WIDTH  registered operands to shared ALU.
REQ-011 o_op_code  out  OPCODE_SZ  registered opcode to shared ALU.
REQ-012 o_gnt0 / o_gnt1  out  1  one-cycle grant pulse, operands captured.
REQ-013 o_done0 / o_done1  out  1  one-cycle pulse, o_result valid for that requester.
REQ-014 o_result  out  DATA_WIDTH  registered result, held until next capture.
REQ-015 o_busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, GRANT, EXEC, DONE; illegal encodings SHALL return to IDLE.
REQ-017 IDLE: no request -> stay; any i_reqN high -> GRANT with winner latched.
REQ-018 Arbitration: round-robin pointer; single request wins; both high -> requester at pointer wins.
REQ-019 Pointer SHALL move to the non-winner on entering DONE; reset value selects requester 0.
REQ-020 GRANT (1 cycle): capture winner's op_a/op_b/op_code into o_op_*, pulse o_gntN, load latency counter with ALU_LAT, -> EXEC.
REQ-021 EXEC: decrement counter each cycle; at count 1 capture i_alu_result into o_result, -> DONE.
REQ-022 DONE (1 cycle): pulse o_doneN for winner, -> IDLE.
REQ-023 Latency: request seen in IDLE at cycle T -> o_gntN at T+1, o_doneN at T+2+ALU_LAT, next grant earliest T+4+ALU_LAT.
REQ-024 o_op_* SHALL stay constant from GRANT through DONE regardless of requester inputs.
REQ-025 Request dropped during GRANT/EXEC/DONE: operation still completes and o_doneN still pulses.
REQ-026 Request held high after o_doneN: treated as a new request in IDLE (requester must drop it to avoid repeat).
REQ-027 Requests arriving while busy are not queued; only levels present in IDLE count.
REQ-028 o_gnt0/o_gnt1 and o_done0/o_done1 SHALL never be high simultaneously.
REQ-029 No arithmetic beyond counter; o_result is i_alu_result unmodified, no width change.

Reset
REQ-030 On i_reset: state IDLE, pointer 0, counter 0, o_op_a/o_op_b/o_op_code/o_result all zero, o_gnt*/o_done*/o_busy low.
REQ-031 Reset mid-operation SHALL abort with no o_done pulse; first post-reset grant follows REQ-023.

Structure
REQ-032 State encodings and default ALU opcodes (ADD 6'b100000, SUB 6'b100010, AND 6'b100100) SHALL live in the shared ALU package.
REQ-033 Round-robin winner selection SHALL be a sub-module rr_arbiter_2 (combinational select from requests + pointer).
REQ-034 The ALU itself SHALL stay outside this block.

Verification
REQ-035 Req0 only, a=8'h05, b=8'h03, ADD, ALU_LAT=1 -> o_gnt0 at T+1, o_done0 at T+3, o_result=8'h08.
REQ-036 Both request in same cycle after reset -> req0 served first, req1 (a=8'h09,b=8'h04,SUB) granted next, o_result=8'h05, o_done1.
REQ-037 Both held high continuously for 4 operations -> grants alternate 0,1,0,1.
REQ-038 Req1 drops one cycle after o_gnt1 -> o_done1 still pulses, o_op_* unchanged through DONE.
REQ-039 ALU_LAT=4, AND a=8'hF0,b=8'h3C -> o_done at T+6, o_result=8'h30.
REQ-040 i_reset asserted in EXEC -> all outputs zero immediately, no o_done, next request served normally.
